mem_arbiter: RTL and testbench

//  Shares the single-port, byte-array data memory between the instruction-fetch

---
 rtl/mem_arb_pkg.sv | 34 +++
 rtl/mem_arb_grant.sv | 47 ++++
 rtl/mem_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and the sub-word merge helper for mem_arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RMW_RD  = 2'd2,
        RMW_WR  = 2'd3
    } arb_state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } ls_size_e;

    // Overlay the low lanes of wdata onto the old memory word at byte offset off.
    function automatic logic [31:0] merge_subword(
        input logic [31:0] old_word,
        input logic [31:0] wdata,
        input logic [1:0]  off,
        input ls_size_e    size
    );
        logic [31:0] r;
        r = old_word;
        case (size)
            SZ_B:    r[{off, 3'b000} +: 8]     = wdata[7:0];
            SZ_H:    r[{off[1], 4'b0000} +: 16] = wdata[15:0];
            default: r = wdata;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// rtl/mem_arb_grant.sv - 2-way IF/LS grant; round-robin when MEM_ARB_RR_EN is defined, else LS-first
module mem_arb_grant (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_if_valid,
    input  logic i_ls_valid,
    output logic o_gnt_if,
    output logic o_gnt_ls
);

    // 0 = IF holds priority on the next contested grant, 1 = LS does.
    logic prio_ls_q;
    logic prio_ls_d;

    // Pick one requester; the pointer only moves when both were competing.
    always_comb begin
        o_gnt_if  = 1'b0;
        o_gnt_ls  = 1'b0;
        prio_ls_d = prio_ls_q;
`ifdef MEM_ARB_RR_EN
        o_gnt_if = i_en && i_if_valid && (!i_ls_valid || !prio_ls_q);
        o_gnt_ls = i_en && i_ls_valid && (!i_if_valid || prio_ls_q);
`else
        o_gnt_ls = i_en && i_ls_valid;
        o_gnt_if = i_en && i_if_valid && !i_ls_valid;
`endif
        if (i_en && i_if_valid && i_ls_valid) begin
            prio_ls_d = o_gnt_if;
        end
    end

    // Pointer register; starts with IF holding priority.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            prio_ls_q <= 1'b0;
        end else begin
            prio_ls_q <= prio_ls_d;
        end
    end

`ifndef MEM_ARB_RR_EN
    logic unused_prio;
    assign unused_prio = prio_ls_q;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one byte-array memory between IF reads and LS loads/stores (MEM_ARB_RR_EN selects round-robin)
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_BYTES = 512
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_if_valid,
    input  logic [31:0] i_if_addr,
    output logic        o_if_ready,
    output logic        o_if_rvalid,
    output logic [31:0] o_if_rdata,
    output logic        o_if_err,
    input  logic        i_ls_valid,
    input  logic        i_ls_we,
    input  logic [1:0]  i_ls_size,
    input  logic [31:0] i_ls_addr,
    input  logic [31:0] i_ls_wdata,
    output logic        o_ls_ready,
    output logic        o_ls_rvalid,
    output logic [31:0] o_ls_rdata,
    output logic        o_ls_err,
    output logic        o_mem_ren,
    output logic        o_mem_wren,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata
);

    arb_state_e  state_q, state_d;
    logic        rsp_if_q, rsp_if_d;
    logic        rsp_ls_q, rsp_ls_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] merged_q, merged_d;
    logic [29:0] rmw_word_q, rmw_word_d;

    logic        gnt_en, gnt_if, gnt_ls;
    logic        if_req, ls_req;
    logic [32:0] if_end, ls_end, ls_bytes;
    logic        if_err, ls_err;

    // Requests are masked while reset is held so every output stays low.
    assign if_req = i_if_valid && i_rst_n;
    assign ls_req = i_ls_valid && i_rst_n;
    assign gnt_en = (state_q == IDLE) || (state_q == RD_WAIT);

    mem_arb_grant u_grant (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_en       (gnt_en),
        .i_if_valid (if_req),
        .i_ls_valid (ls_req),
        .o_gnt_if   (gnt_if),
        .o_gnt_ls   (gnt_ls)
    );

    assign ls_bytes = (i_ls_size == 2'd0) ? 33'd1 : (i_ls_size == 2'd1) ? 33'd2 : 33'd4;
    assign if_end   = {1'b0, i_if_addr} + 33'd4;
    assign ls_end   = {1'b0, i_ls_addr} + ls_bytes;
    assign if_err   = (i_if_addr[1:0] != 2'b00) || (if_end > 33'(MEM_BYTES));
    assign ls_err   = (i_ls_size == 2'd3)
                   || ((i_ls_size == 2'd1) && i_ls_addr[0])
                   || ((i_ls_size == 2'd2) && (i_ls_addr[1:0] != 2'b00))
                   || (ls_end > 33'(MEM_BYTES));

    // Next-state, handshake and memory command decode.
    always_comb begin
        state_d     = state_q;
        rsp_if_d    = 1'b0;
        rsp_ls_d    = 1'b0;
        rsp_err_d   = 1'b0;
        merged_d    = merged_q;
        rmw_word_d  = rmw_word_q;
        o_if_ready  = 1'b0;
        o_ls_ready  = 1'b0;
        o_mem_ren   = 1'b0;
        o_mem_wren  = 1'b0;
        o_mem_addr  = 32'h0;
        o_mem_wdata = 32'h0;
        case (state_q)
            IDLE, RD_WAIT: begin
                state_d = IDLE;
                if (gnt_if) begin
                    o_if_ready = 1'b1;
                    rsp_if_d   = 1'b1;
                    if (if_err) begin
                        rsp_err_d = 1'b1;
                    end else begin
                        o_mem_ren  = 1'b1;
                        o_mem_addr = {i_if_addr[31:2], 2'b00};
                        state_d    = RD_WAIT;
                    end
                end else if (gnt_ls) begin
                    if (ls_err) begin
                        o_ls_ready = 1'b1;
                        rsp_ls_d   = 1'b1;
                        rsp_err_d  = 1'b1;
                    end else if (!i_ls_we) begin
                        o_ls_ready = 1'b1;
                        rsp_ls_d   = 1'b1;
                        o_mem_ren  = 1'b1;
                        o_mem_addr = {i_ls_addr[31:2], 2'b00};
                        state_d    = RD_WAIT;
                    end else if (i_ls_size == 2'd2) begin
                        o_ls_ready  = 1'b1;
                        rsp_ls_d    = 1'b1;
                        o_mem_wren  = 1'b1;
                        o_mem_addr  = {i_ls_addr[31:2], 2'b00};
                        o_mem_wdata = i_ls_wdata;
                    end else begin
                        // Sub-word store: fetch the old word, accept next cycle.
                        o_mem_ren  = 1'b1;
                        o_mem_addr = {i_ls_addr[31:2], 2'b00};
                        state_d    = RMW_RD;
                    end
                end
            end
            RMW_RD: begin
                o_ls_ready = 1'b1;
                merged_d   = merge_subword(i_mem_rdata, i_ls_wdata, i_ls_addr[1:0],
                                           ls_size_e'(i_ls_size));
                rmw_word_d = i_ls_addr[31:2];
                state_d    = RMW_WR;
            end
            RMW_WR: begin
                o_mem_wren  = 1'b1;
                o_mem_addr  = {rmw_word_q, 2'b00};
                o_mem_wdata = merged_q;
                rsp_ls_d    = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, pending-response flags and the RMW holding registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            rsp_if_q   <= 1'b0;
            rsp_ls_q   <= 1'b0;
            rsp_err_q  <= 1'b0;
            merged_q   <= 32'h0;
            rmw_word_q <= 30'h0;
        end else begin
            state_q    <= state_d;
            rsp_if_q   <= rsp_if_d;
            rsp_ls_q   <= rsp_ls_d;
            rsp_err_q  <= rsp_err_d;
            merged_q   <= merged_d;
            rmw_word_q <= rmw_word_d;
        end
    end

    // Read data is only forwarded in RD_WAIT; error and store responses carry zero.
    assign o_if_rvalid = rsp_if_q;
    assign o_ls_rvalid = rsp_ls_q;
    assign o_if_err    = rsp_if_q && rsp_err_q;
    assign o_ls_err    = rsp_ls_q && rsp_err_q;
    assign o_if_rdata  = (rsp_if_q && (state_q == RD_WAIT)) ? i_mem_rdata : 32'h0;
    assign o_ls_rdata  = (rsp_ls_q && (state_q == RD_WAIT)) ? i_mem_rdata : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter with a byte-array memory model
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid;
    logic [31:0] if_addr;
    logic        o_if_ready, o_if_rvalid, o_if_err;
    logic [31:0] o_if_rdata;
    logic        ls_valid, ls_we;
    logic [1:0]  ls_size;
    logic [31:0] ls_addr, ls_wdata;
    logic        o_ls_ready, o_ls_rvalid, o_ls_err;
    logic [31:0] o_ls_rdata;
    logic        o_mem_ren, o_mem_wren;
    logic [31:0] o_mem_addr, o_mem_wdata;
    logic [31:0] mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.MEM_BYTES(512)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_if_valid  (if_valid),
        .i_if_addr   (if_addr),
        .o_if_ready  (o_if_ready),
        .o_if_rvalid (o_if_rvalid),
        .o_if_rdata  (o_if_rdata),
        .o_if_err    (o_if_err),
        .i_ls_valid  (ls_valid),
        .i_ls_we     (ls_we),
        .i_ls_size   (ls_size),
        .i_ls_addr   (ls_addr),
        .i_ls_wdata  (ls_wdata),
        .o_ls_ready  (o_ls_ready),
        .o_ls_rvalid (o_ls_rvalid),
        .o_ls_rdata  (o_ls_rdata),
        .o_ls_err    (o_ls_err),
        .o_mem_ren   (o_mem_ren),
        .o_mem_wren  (o_mem_wren),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_rdata (mem_rdata)
    );

    // Memory model: synchronous read, byte-array storage, op counters.
    logic [7:0] mem [0:511];
    logic       preload;
    int         ren_cnt, wren_cnt;
    logic [8:0] ma;
    assign ma = o_mem_addr[8:0];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 512; i++) mem[i] <= 8'h00;
            mem[9'h010] <= 8'h11; mem[9'h011] <= 8'h22; mem[9'h012] <= 8'h33; mem[9'h013] <= 8'h44;
            mem[9'h020] <= 8'h11; mem[9'h021] <= 8'h22; mem[9'h022] <= 8'h33; mem[9'h023] <= 8'h44;
            mem[9'h028] <= 8'h01; mem[9'h029] <= 8'h02; mem[9'h02A] <= 8'h03; mem[9'h02B] <= 8'h04;
            mem[9'h040] <= 8'hEF; mem[9'h041] <= 8'hBE; mem[9'h042] <= 8'hAD; mem[9'h043] <= 8'hDE;
            mem_rdata <= 32'h0;
            ren_cnt   <= 0;
            wren_cnt  <= 0;
        end else begin
            if (o_mem_ren) begin
                mem_rdata <= {mem[ma + 9'd3], mem[ma + 9'd2], mem[ma + 9'd1], mem[ma]};
                ren_cnt   <= ren_cnt + 1;
            end
            if (o_mem_wren) begin
                mem[ma]         <= o_mem_wdata[7:0];
                mem[ma + 9'd1]  <= o_mem_wdata[15:8];
                mem[ma + 9'd2]  <= o_mem_wdata[23:16];
                mem[ma + 9'd3]  <= o_mem_wdata[31:24];
                wren_cnt        <= wren_cnt + 1;
            end
        end
    end

    function automatic logic [31:0] rd_word(input int a);
        return {mem[a + 3], mem[a + 2], mem[a + 1], mem[a]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic ls_txn(input logic we, input logic [1:0] sz, input logic [31:0] ad,
                          input logic [31:0] wd, output logic [31:0] rd, output logic er,
                          output int waitc, output int lat);
        int  cyc;
        int  k;
        bit  done;
        @(negedge clk);
        ls_valid = 1'b1; ls_we = we; ls_size = sz; ls_addr = ad; ls_wdata = wd;
        cyc = 0; done = 1'b0;
        while (!done && cyc < 8) begin
            #1;
            if (o_ls_ready) done = 1'b1;
            @(negedge clk);
            cyc++;
        end
        ls_valid = 1'b0;
        chk("ls_accept", 32'(done), 32'd1);
        k = 0; rd = 32'h0; er = 1'b0;
        while (k < 8) begin
            #1;
            if (o_ls_rvalid) begin
                rd = o_ls_rdata;
                er = o_ls_err;
                break;
            end
            @(negedge clk);
            k++;
        end
        chk("ls_rvalid_seen", 32'(k < 8), 32'd1);
        waitc = cyc - 1;
        lat   = k + 1;
    endtask

    task automatic if_txn(input logic [31:0] ad, output logic [31:0] rd, output logic er,
                          output int lat);
        int  cyc;
        int  k;
        bit  done;
        @(negedge clk);
        if_valid = 1'b1; if_addr = ad;
        cyc = 0; done = 1'b0;
        while (!done && cyc < 8) begin
            #1;
            if (o_if_ready) done = 1'b1;
            @(negedge clk);
            cyc++;
        end
        if_valid = 1'b0;
        chk("if_accept", 32'(done), 32'd1);
        k = 0; rd = 32'h0; er = 1'b0;
        while (k < 8) begin
            #1;
            if (o_if_rvalid) begin
                rd = o_if_rdata;
                er = o_if_err;
                break;
            end
            @(negedge clk);
            k++;
        end
        chk("if_rvalid_seen", 32'(k < 8), 32'd1);
        lat = k + 1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          waitc, lat, rc, wc;
        logic        e_we [6];
        logic [1:0]  e_sz [6];
        logic [31:0] e_ad [6];
        logic        exp_if [3];

        rst_n = 1'b0; preload = 1'b1;
        if_valid = 1'b0; if_addr = 32'h0;
        ls_valid = 1'b0; ls_we = 1'b0; ls_size = 2'd0; ls_addr = 32'h0; ls_wdata = 32'h0;

        // Reset: outputs low even with requests present.
        repeat (2) @(negedge clk);
        if_valid = 1'b1; if_addr = 32'h10; ls_valid = 1'b1; ls_addr = 32'h40; ls_size = 2'd2;
        #1;
        chk("rst_if_ready", 32'(o_if_ready), 32'd0);
        chk("rst_ls_ready", 32'(o_ls_ready), 32'd0);
        chk("rst_ren", 32'(o_mem_ren), 32'd0);
        chk("rst_wren", 32'(o_mem_wren), 32'd0);
        chk("rst_rvalid", 32'({o_if_rvalid, o_ls_rvalid}), 32'd0);
        @(negedge clk);
        if_valid = 1'b0; ls_valid = 1'b0; preload = 1'b0; rst_n = 1'b1;

        // IF read of 0x10 alone.
        @(negedge clk);
        if_valid = 1'b1; if_addr = 32'h10;
        #1;
        chk("if_ready", 32'(o_if_ready), 32'd1);
        chk("if_ren", 32'(o_mem_ren), 32'd1);
        chk("if_mem_addr", o_mem_addr, 32'h10);
        @(negedge clk);
        if_valid = 1'b0;
        #1;
        chk("if_rvalid", 32'(o_if_rvalid), 32'd1);
        chk("if_rdata", o_if_rdata, 32'h44332211);
        chk("if_err", 32'(o_if_err), 32'd0);
        @(negedge clk);
        #1;
        chk("if_rvalid_drop", 32'(o_if_rvalid), 32'd0);

        // LS store byte 0xAB at 0x21 as read-modify-write.
        @(negedge clk);
        ls_valid = 1'b1; ls_we = 1'b1; ls_size = 2'd0; ls_addr = 32'h21; ls_wdata = 32'hFFFFFFAB;
        #1;
        chk("sb_ren", 32'(o_mem_ren), 32'd1);
        chk("sb_ren_addr", o_mem_addr, 32'h20);
        chk("sb_ready_n", 32'(o_ls_ready), 32'd0);
        @(negedge clk);
        #1;
        chk("sb_rmwrd_ready", 32'(o_ls_ready), 32'd1);
        chk("sb_rmwrd_idle", 32'({o_mem_ren, o_mem_wren}), 32'd0);
        @(negedge clk);
        ls_valid = 1'b0;
        #1;
        chk("sb_wren", 32'(o_mem_wren), 32'd1);
        chk("sb_wdata", o_mem_wdata, 32'h4433AB11);
        chk("sb_waddr", o_mem_addr, 32'h20);
        chk("sb_no_rvalid_yet", 32'(o_ls_rvalid), 32'd0);
        @(negedge clk);
        #1;
        chk("sb_rvalid", 32'(o_ls_rvalid), 32'd1);
        chk("sb_err", 32'(o_ls_err), 32'd0);
        chk("sb_mem", rd_word(32'h20), 32'h4433AB11);

        // Legal loads/stores including the top-of-memory boundary.
        ls_txn(1'b1, 2'd1, 32'h22, 32'h1234BEEF, rd, er, waitc, lat);
        chk("sh_err", 32'(er), 32'd0);
        chk("sh_wait", 32'(waitc), 32'd1);
        chk("sh_lat", 32'(lat), 32'd2);
        ls_txn(1'b0, 2'd2, 32'h20, 32'h0, rd, er, waitc, lat);
        chk("lw20_data", rd, 32'hBEEFAB11);
        chk("lw20_lat", 32'(lat), 32'd1);
        ls_txn(1'b0, 2'd2, 32'h40, 32'h0, rd, er, waitc, lat);
        chk("lw40_data", rd, 32'hDEADBEEF);
        chk("lw40_err", 32'(er), 32'd0);
        ls_txn(1'b1, 2'd2, 32'h1FC, 32'hCAFEF00D, rd, er, waitc, lat);
        chk("sw1fc_err", 32'(er), 32'd0);
        chk("sw1fc_wait", 32'(waitc), 32'd0);
        chk("sw1fc_lat", 32'(lat), 32'd1);
        chk("sw1fc_mem", rd_word(32'h1FC), 32'hCAFEF00D);
        ls_txn(1'b0, 2'd0, 32'h1FF, 32'h0, rd, er, waitc, lat);
        chk("lb1ff_err", 32'(er), 32'd0);
        chk("lb1ff_data", rd, 32'hCAFEF00D);

        // Erroring LS requests: no memory op, 1-cycle err response.
        e_we[0] = 1'b1; e_sz[0] = 2'd2; e_ad[0] = 32'h200;
        e_we[1] = 1'b1; e_sz[1] = 2'd1; e_ad[1] = 32'h23;
        e_we[2] = 1'b0; e_sz[2] = 2'd2; e_ad[2] = 32'h42;
        e_we[3] = 1'b0; e_sz[3] = 2'd3; e_ad[3] = 32'h0;
        e_we[4] = 1'b0; e_sz[4] = 2'd1; e_ad[4] = 32'h1FF;
        e_we[5] = 1'b1; e_sz[5] = 2'd0; e_ad[5] = 32'h200;
        for (int i = 0; i < 6; i++) begin
            rc = ren_cnt; wc = wren_cnt;
            ls_txn(e_we[i], e_sz[i], e_ad[i], 32'h5A5A5A5A, rd, er, waitc, lat);
            chk($sformatf("lserr%0d_err", i), 32'(er), 32'd1);
            chk($sformatf("lserr%0d_lat", i), 32'(lat), 32'd1);
            chk($sformatf("lserr%0d_memops", i), 32'((ren_cnt - rc) + (wren_cnt - wc)), 32'd0);
        end

        // IF errors and a boundary IF read.
        rc = ren_cnt;
        if_txn(32'h12, rd, er, lat);
        chk("if12_err", 32'(er), 32'd1);
        chk("if12_lat", 32'(lat), 32'd1);
        if_txn(32'h200, rd, er, lat);
        chk("if200_err", 32'(er), 32'd1);
        chk("iferr_no_ren", 32'(ren_cnt - rc), 32'd0);
        if_txn(32'h1FC, rd, er, lat);
        chk("if1fc_err", 32'(er), 32'd0);
        chk("if1fc_data", rd, 32'hCAFEF00D);

        // Both ports valid every cycle with loads.
`ifdef MEM_ARB_RR_EN
        exp_if[0] = 1'b1; exp_if[1] = 1'b0; exp_if[2] = 1'b1;
`else
        exp_if[0] = 1'b0; exp_if[1] = 1'b0; exp_if[2] = 1'b0;
`endif
        @(negedge clk);
        if_valid = 1'b1; if_addr = 32'h10;
        ls_valid = 1'b1; ls_we = 1'b0; ls_size = 2'd2; ls_addr = 32'h40;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("arb%0d_if_ready", c), 32'(o_if_ready), 32'(exp_if[c]));
            chk($sformatf("arb%0d_ls_ready", c), 32'(o_ls_ready), 32'(!exp_if[c]));
            if (c > 0) begin
                if (exp_if[c - 1]) begin
                    chk($sformatf("arb%0d_if_rdata", c), o_if_rdata, 32'h44332211);
                    chk($sformatf("arb%0d_if_rvalid", c), 32'(o_if_rvalid), 32'd1);
                end else begin
                    chk($sformatf("arb%0d_ls_rdata", c), o_ls_rdata, 32'hDEADBEEF);
                    chk($sformatf("arb%0d_ls_rvalid", c), 32'(o_ls_rvalid), 32'd1);
                end
            end
            @(negedge clk);
        end
        if_valid = 1'b0; ls_valid = 1'b0;
        #1;
        chk("arb_last_rvalid", 32'({o_if_rvalid, o_ls_rvalid}), exp_if[2] ? 32'd2 : 32'd1);

        // IF waits out a sub-word store.
        @(negedge clk);
        ls_valid = 1'b1; ls_we = 1'b1; ls_size = 2'd0; ls_addr = 32'h24; ls_wdata = 32'h00000077;
        if_valid = 1'b1; if_addr = 32'h10;
        #1;
        chk("rmwif_ren", 32'(o_mem_ren), 32'd1);
        chk("rmwif_if_ready0", 32'(o_if_ready), 32'd0);
        @(negedge clk);
        #1;
        chk("rmwif_ls_ready", 32'(o_ls_ready), 32'd1);
        chk("rmwif_if_ready1", 32'(o_if_ready), 32'd0);
        @(negedge clk);
        ls_valid = 1'b0;
        #1;
        chk("rmwif_wren", 32'(o_mem_wren), 32'd1);
        chk("rmwif_if_ready2", 32'(o_if_ready), 32'd0);
        @(negedge clk);
        #1;
        chk("rmwif_if_granted", 32'(o_if_ready), 32'd1);
        chk("rmwif_ls_rvalid", 32'(o_ls_rvalid), 32'd1);
        @(negedge clk);
        if_valid = 1'b0;
        #1;
        chk("rmwif_if_rdata", o_if_rdata, 32'h44332211);
        chk("rmwif_mem", rd_word(32'h24), 32'h00000077);

        // Reset while in RMW_RD aborts the store.
        @(negedge clk);
        ls_valid = 1'b1; ls_we = 1'b1; ls_size = 2'd0; ls_addr = 32'h28; ls_wdata = 32'h00000055;
        #1;
        chk("rstrmw_ren", 32'(o_mem_ren), 32'd1);
        @(negedge clk);
        #1;
        chk("rstrmw_in_rmwrd", 32'(o_ls_ready), 32'd1);
        wc = wren_cnt;
        rst_n = 1'b0; ls_valid = 1'b0;
        #1;
        chk("rstrmw_outputs", 32'({o_ls_ready, o_mem_ren, o_mem_wren, o_ls_rvalid}), 32'd0);
        @(negedge clk);
        #1;
        chk("rstrmw_no_wren", 32'(o_mem_wren), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("rstrmw_no_rvalid", 32'(o_ls_rvalid), 32'd0);
        chk("rstrmw_wren_cnt", 32'(wren_cnt - wc), 32'd0);
        chk("rstrmw_mem", rd_word(32'h28), 32'h04030201);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
